// File: rtl/de2_115_ir_nec_decoder.sv
// NEC infrared frame decoder behind an Avalon-MM slave: sync, glitch filter, width timer, NEC FSM, CSRs.
// Optional `IR_CHECKSUM_EN: reject frames whose inverted address/command bytes do not match.
module de2_115_ir_nec_decoder #(
    parameter int TICKS_PER_US = 50,
    parameter int GLITCH_CYC   = 8,
    parameter int TIME_SCALE   = 1   // >1 shrinks every NEC window by this factor (fast simulation)
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        ir_in,
    input  logic [1:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        irq
);

    localparam int GW = $clog2(GLITCH_CYC + 1);
    localparam int TW = $clog2(TICKS_PER_US + 1);

    localparam logic [13:0] W_MAX   = 14'h3FFF;
    localparam logic [13:0] LM_MIN  = 14'(8000 / TIME_SCALE);
    localparam logic [13:0] LM_MAX  = 14'(10000 / TIME_SCALE);
    localparam logic [13:0] LS_MIN  = 14'(4000 / TIME_SCALE);
    localparam logic [13:0] LS_MAX  = 14'(5000 / TIME_SCALE);
    localparam logic [13:0] RS_MIN  = 14'(2000 / TIME_SCALE);
    localparam logic [13:0] RS_MAX  = 14'(2500 / TIME_SCALE);
    localparam logic [13:0] BM_MIN  = 14'(400 / TIME_SCALE);
    localparam logic [13:0] BM_MAX  = 14'(720 / TIME_SCALE);
    localparam logic [13:0] B1_MIN  = 14'(1400 / TIME_SCALE);
    localparam logic [13:0] B1_MAX  = 14'(1900 / TIME_SCALE);
    localparam logic [13:0] TO_W    = 14'(12000 / TIME_SCALE);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD_MARK, S_LEAD_SPACE, S_BIT_MARK, S_BIT_SPACE, S_RPT_MARK, S_DONE
    } state_t;

    function automatic logic in_rng(input logic [13:0] w, input logic [13:0] lo, input logic [13:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    logic          sync1_q, sync1_d, sync2_q, sync2_d, filt_q, filt_d;
    logic [GW-1:0] gcnt_q, gcnt_d;
    logic [TW-1:0] tick_cnt_q, tick_cnt_d;
    logic [13:0]   width_q, width_d;
    state_t        state_q, state_d;
    logic [5:0]    bitcnt_q, bitcnt_d;
    logic [31:0]   shreg_q, shreg_d, data_q, data_d, readdata_q, readdata_d;
    logic          valid_q, valid_d, repeat_q, repeat_d, overrun_q, overrun_d, csum_q, csum_d;
    logic          enable_q, enable_d, irq_en_q, irq_en_d;

    logic flip, fall, rise, tick, done_set, rpt_set, frame_ok;
    logic unused_wd;

    assign unused_wd = ^writedata[31:4];

    always_comb begin
        sync1_d    = ir_in;
        sync2_d    = sync1_q;
        filt_d     = filt_q;
        gcnt_d     = '0;
        tick_cnt_d = tick_cnt_q;
        width_d    = width_q;
        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shreg_d    = shreg_q;
        data_d     = data_q;
        readdata_d = readdata_q;
        valid_d    = valid_q;
        repeat_d   = repeat_q;
        overrun_d  = overrun_q;
        csum_d     = csum_q;
        enable_d   = enable_q;
        irq_en_d   = irq_en_q;
        flip       = 1'b0;
        tick       = 1'b0;
        done_set   = 1'b0;
        rpt_set    = 1'b0;

        // A new level is accepted only after GLITCH_CYC consecutive differing samples.
        if (sync2_q != filt_q) begin
            if (gcnt_q == GW'(GLITCH_CYC - 1)) begin
                flip   = 1'b1;
                filt_d = sync2_q;
            end else begin
                gcnt_d = gcnt_q + GW'(1);
            end
        end
        fall = flip & filt_q;
        rise = flip & ~filt_q;

        if (tick_cnt_q == TW'(TICKS_PER_US - 1)) begin
            tick       = 1'b1;
            tick_cnt_d = '0;
        end else begin
            tick_cnt_d = tick_cnt_q + TW'(1);
        end

        if (flip)
            width_d = '0;
        else if (tick && width_q != W_MAX)
            width_d = width_q + 14'd1;

        case (state_q)
            S_IDLE:       if (fall && enable_q) state_d = S_LEAD_MARK;
            S_LEAD_MARK:  if (rise) state_d = in_rng(width_q, LM_MIN, LM_MAX) ? S_LEAD_SPACE : S_IDLE;
            S_LEAD_SPACE: if (fall) begin
                if (in_rng(width_q, LS_MIN, LS_MAX)) begin
                    state_d  = S_BIT_MARK;
                    bitcnt_d = '0;
                end else if (in_rng(width_q, RS_MIN, RS_MAX)) begin
                    state_d = S_RPT_MARK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BIT_MARK:   if (rise) begin
                if (in_rng(width_q, BM_MIN, BM_MAX))
                    state_d = (bitcnt_q == 6'd32) ? S_DONE : S_BIT_SPACE;
                else
                    state_d = S_IDLE;
            end
            S_BIT_SPACE:  if (fall) begin
                state_d  = S_BIT_MARK;
                bitcnt_d = bitcnt_q + 6'd1;
                if (in_rng(width_q, BM_MIN, BM_MAX))
                    shreg_d = {1'b0, shreg_q[31:1]};
                else if (in_rng(width_q, B1_MIN, B1_MAX))
                    shreg_d = {1'b1, shreg_q[31:1]};
                else
                    state_d = S_IDLE;
            end
            S_RPT_MARK:   if (rise) begin
                rpt_set = in_rng(width_q, BM_MIN, BM_MAX);
                state_d = S_IDLE;
            end
            S_DONE: begin
                done_set = 1'b1;
                state_d  = S_IDLE;
            end
            default:      state_d = S_IDLE;
        endcase

        // Line stuck without an edge: abandon the frame silently.
        if (state_q != S_IDLE && state_q != S_DONE && width_q >= TO_W)
            state_d = S_IDLE;
        if (!enable_q)
            state_d = S_IDLE;

`ifdef IR_CHECKSUM_EN
        frame_ok = (shreg_q[31:24] == ~shreg_q[23:16]) && (shreg_q[15:8] == ~shreg_q[7:0]);
`else
        frame_ok = 1'b1;
`endif

        // Clears first, so same-cycle flag sets below take priority.
        if (read && address == 2'd0)
            valid_d = 1'b0;
        if (write && address == 2'd1) begin
            if (writedata[0]) valid_d   = 1'b0;
            if (writedata[1]) repeat_d  = 1'b0;
            if (writedata[2]) overrun_d = 1'b0;
            if (writedata[3]) csum_d    = 1'b0;
        end
        if (write && address == 2'd2) begin
            enable_d = writedata[0];
            irq_en_d = writedata[1];
        end
        if (rpt_set)
            repeat_d = 1'b1;
        if (done_set && frame_ok) begin
            data_d  = shreg_q;
            valid_d = 1'b1;
            if (valid_q) overrun_d = 1'b1;
        end
        if (done_set && !frame_ok)
            csum_d = 1'b1;

        if (read) begin
            case (address)
                2'd0:    readdata_d = data_q;
                2'd1:    readdata_d = {28'd0, csum_q, overrun_q, repeat_q, valid_q};
                2'd2:    readdata_d = {30'd0, irq_en_q, enable_q};
                default: readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q    <= 1'b1;
            sync2_q    <= 1'b1;
            filt_q     <= 1'b1;
            gcnt_q     <= '0;
            tick_cnt_q <= '0;
            width_q    <= '0;
            state_q    <= S_IDLE;
            bitcnt_q   <= '0;
            shreg_q    <= '0;
            data_q     <= '0;
            readdata_q <= '0;
            valid_q    <= 1'b0;
            repeat_q   <= 1'b0;
            overrun_q  <= 1'b0;
            csum_q     <= 1'b0;
            enable_q   <= 1'b0;
            irq_en_q   <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            filt_q     <= filt_d;
            gcnt_q     <= gcnt_d;
            tick_cnt_q <= tick_cnt_d;
            width_q    <= width_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shreg_q    <= shreg_d;
            data_q     <= data_d;
            readdata_q <= readdata_d;
            valid_q    <= valid_d;
            repeat_q   <= repeat_d;
            overrun_q  <= overrun_d;
            csum_q     <= csum_d;
            enable_q   <= enable_d;
            irq_en_q   <= irq_en_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_en_q & (valid_q | repeat_q);

endmodule

// File: tb/tb_de2_115_ir_nec_decoder.sv
// Bench for the NEC decoder: table of frames plus hand-built repeat/overrun/glitch/timeout/reset sequences.
// Runs with TICKS_PER_US=1, TIME_SCALE=20, so one clk cycle stands for 20 us of IR time.
module tb_de2_115_ir_nec_decoder;

    localparam int LEAD = 450;   // 9000 us
    localparam int LSP  = 225;   // 4500 us
    localparam int RSP  = 112;   // 2250 us
    localparam int BM   = 28;    // 560 us
    localparam int B0   = 28;
    localparam int B1   = 84;    // 1690 us
    localparam int GAP  = 60;

    logic        clk, reset_n, ir_in, read, write, irq;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;

    int n_pass = 0;
    int n_total = 0;
    logic [31:0] exp_q[$];

    de2_115_ir_nec_decoder #(.TICKS_PER_US(1), .GLITCH_CYC(8), .TIME_SCALE(20)) dut (
        .clk(clk), .reset_n(reset_n), .ir_in(ir_in), .address(address), .read(read),
        .write(write), .writedata(writedata), .readdata(readdata), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  c;
        logic [7:0]  ci;
        logic [31:0] exp_data;
        logic [31:0] exp_status;
    } vec_t;
    vec_t vecs[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pulse(input logic lvl, input int n);
        ir_in = lvl;
        repeat (n) @(negedge clk);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        @(negedge clk);
        address = a; read = 1'b1;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address = a; writedata = d; write = 1'b1;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic chk_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
        logic [31:0] d;
        rd(a, d);
        chk(name, d, exp);
    endtask

    task automatic send_bits(input logic [31:0] w, input int nbits);
        pulse(1'b0, LEAD);
        pulse(1'b1, LSP);
        for (int i = 0; i < nbits; i++) begin
            pulse(1'b0, BM);
            pulse(1'b1, w[i] ? B1 : B0);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] ci);
        send_bits({ci, c, ~a, a}, 32);
        pulse(1'b0, BM);
        pulse(1'b1, GAP);
    endtask

    task automatic send_repeat();
        pulse(1'b0, LEAD);
        pulse(1'b1, RSP);
        pulse(1'b0, BM);
        pulse(1'b1, GAP);
    endtask

    // Pop the scoreboard and compare against a DATA read.
    task automatic chk_data(input string name);
        logic [31:0] d, e;
        rd(2'd0, d);
        if (exp_q.size() == 0) begin
            n_total++;
            $display("FAIL %s: got %h expected <scoreboard empty>", name, d);
        end else begin
            e = exp_q.pop_front();
            chk(name, d, e);
        end
    endtask

    initial begin
        vecs[0] = '{a: 8'h04, c: 8'h08, ci: 8'hF7, exp_data: 32'hF708FB04, exp_status: 32'h1};
        vecs[1] = '{a: 8'h00, c: 8'h45, ci: 8'hBA, exp_data: 32'hBA45FF00, exp_status: 32'h1};
        vecs[2] = '{a: 8'hFF, c: 8'h00, ci: 8'hFF, exp_data: 32'hFF0000FF, exp_status: 32'h1};
        vecs[3] = '{a: 8'h5A, c: 8'hA5, ci: 8'h5A, exp_data: 32'h5AA5A55A, exp_status: 32'h1};

        reset_n = 1'b0; ir_in = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (4) @(negedge clk);
        chk("reset_readdata", readdata, 32'h0);
        chk("reset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reg("reset_status", 2'd1, 32'h0);
        chk_reg("reset_control", 2'd2, 32'h0);
        chk_reg("addr3_zero", 2'd3, 32'h0);

        // Disabled decoder ignores a full frame.
        send_frame(8'h04, 8'h08, 8'hF7);
        chk_reg("disabled_status", 2'd1, 32'h0);

        wr(2'd2, 32'hFFFF_FFFD);
        chk_reg("control_rw", 2'd2, 32'h1);

        foreach (vecs[i]) begin
            send_frame(vecs[i].a, vecs[i].c, vecs[i].ci);
            exp_q.push_back(vecs[i].exp_data);
            chk_reg($sformatf("vec%0d_status", i), 2'd1, vecs[i].exp_status);
            chk($sformatf("vec%0d_irq_off", i), {31'd0, irq}, 32'h0);
            chk_data($sformatf("vec%0d_data", i));
            chk_reg($sformatf("vec%0d_valid_clr", i), 2'd1, 32'h0);
        end

        // irq and repeat codes.
        wr(2'd2, 32'h3);
        send_frame(8'h04, 8'h08, 8'hF7);
        exp_q.push_back(32'hF708FB04);
        chk("irq_valid", {31'd0, irq}, 32'h1);
        send_repeat();
        chk_reg("repeat_status", 2'd1, 32'h3);
        chk_data("repeat_data_kept");
        chk_reg("repeat_after_read", 2'd1, 32'h2);
        chk("irq_repeat", {31'd0, irq}, 32'h1);
        wr(2'd1, 32'h2);
        chk_reg("repeat_w1c", 2'd1, 32'h0);
        chk("irq_cleared", {31'd0, irq}, 32'h0);

        // Overrun: second frame replaces the unread first one.
        send_frame(8'h04, 8'h08, 8'hF7);
        send_frame(8'h00, 8'h45, 8'hBA);
        exp_q.push_back(32'hBA45FF00);
        chk_reg("overrun_status", 2'd1, 32'h5);
        chk_data("overrun_data");
        chk_reg("overrun_valid_clr", 2'd1, 32'h4);
        wr(2'd1, 32'h4);
        chk_reg("overrun_w1c", 2'd1, 32'h0);

        // Inverted command byte wrong.
        send_frame(8'h04, 8'h08, 8'h00);
`ifdef IR_CHECKSUM_EN
        chk_reg("csum_status", 2'd1, 32'h8);
        wr(2'd1, 32'h8);
`else
        exp_q.push_back(32'h0008FB04);
        chk_reg("csum_off_status", 2'd1, 32'h1);
        chk_data("csum_off_data");
`endif
        chk_reg("csum_cleared", 2'd1, 32'h0);

        // Short glitches and a too-short leader leave no trace.
        for (int i = 0; i < 5; i++) begin
            pulse(1'b0, 3);
            pulse(1'b1, 20);
        end
        pulse(1'b0, 300);
        pulse(1'b1, GAP);
        chk_reg("glitch_status", 2'd1, 32'h0);
        chk("glitch_irq", {31'd0, irq}, 32'h0);

        // Partial frame then a silent line: timeout back to IDLE.
        send_bits(32'hF708FB04, 5);
        pulse(1'b1, 700);
        chk_reg("timeout_status", 2'd1, 32'h0);
        send_frame(8'h5A, 8'hA5, 8'h5A);
        exp_q.push_back(32'h5AA5A55A);
        chk_data("after_timeout_data");

        // Reset in the middle of a frame with irq asserted.
        send_frame(8'h04, 8'h08, 8'hF7);
        chk("pre_reset_irq", {31'd0, irq}, 32'h1);
        send_bits(32'hBA45FF00, 10);
        reset_n = 1'b0;
        ir_in = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_readdata", readdata, 32'h0);
        chk("midreset_irq", {31'd0, irq}, 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        chk_reg("postreset_control", 2'd2, 32'h0);
        chk_reg("postreset_status", 2'd1, 32'h0);
        wr(2'd2, 32'h1);
        send_frame(8'h04, 8'h08, 8'hF7);
        exp_q.push_back(32'hF708FB04);
        chk_reg("postreset_valid", 2'd1, 32'h1);
        chk_data("postreset_data");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
